// File: rtl/z80_arb_pkg.sv
// z80_arb_pkg: shared types and default parameter values for the Z80 bus
// arbiter slice (z80_bus_arbiter, rr_pick).
// Optional feature macro used by the slice: Z80_ARB_FAIRNESS_EN.
package z80_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACQ,
    ST_GRANT,
    ST_TURN,
    ST_REL,
    ST_CPU_SLOT
  } arb_state_e;

  // Index of a bus master; wide enough for the 4-master maximum.
  typedef logic [1:0] owner_t;

  localparam int unsigned NREQ_DEF     = 2;
  localparam int unsigned GUARD_DEF    = 1;
  localparam int unsigned MAX_HOLD_DEF = 64;
  localparam int unsigned CPU_SLOT_DEF = 4;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports:
//   req        in   NREQ  per-master request vector
//   last_owner in   2     index of the most recent grant
//   winner     out  2     first requester searching upward from last_owner+1
//   valid      out  1     at least one request is pending
module rr_pick
  import z80_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0] req,
  input  owner_t          last_owner,
  output owner_t          winner,
  output logic            valid
);

  int unsigned last_u;
  int unsigned best;

  assign last_u = 32'(last_owner);

  // Each requester's distance from last_owner+1 (mod NREQ); smallest wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    best   = NREQ;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (req[j] && (((j + NREQ - 1 - last_u) % NREQ) < best)) begin
        best   = (j + NREQ - 1 - last_u) % NREQ;
        winner = owner_t'(j);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/z80_bus_arbiter.sv
// z80_bus_arbiter: shares the Z80 system bus between the CPU and NREQ bus
// masters. Takes the bus via BUSRQ/BUSACK, grants one master at a time in
// round-robin order with a GUARD-cycle gap between owners, and hands the bus
// back to the CPU once no master is requesting. All state advances on cen.
// Optional macro Z80_ARB_FAIRNESS_EN: bounds master ownership to MAX_HOLD
// cycles, then forces CPU_SLOT CPU-owned cycles and pulses preempt.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   cen           clock enable; all state holds while low
//   req           per-master level request
//   gnt           per-master grant, one-hot or zero
//   owner         index of the granted master (valid while |gnt)
//   cpu_busrq_n   to Z80 BUSRQ (active low)
//   cpu_busack_n  from Z80 BUSACK (active low), sampled once per cen cycle
//   bus_oe        master address/data mux enable, equals |gnt
//   preempt       one-cycle pulse when a grant is revoked by hold expiry
module z80_bus_arbiter
  import z80_arb_pkg::*;
#(
  parameter int unsigned NREQ     = NREQ_DEF,
  parameter int unsigned GUARD    = GUARD_DEF,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
  parameter int unsigned CPU_SLOT = CPU_SLOT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output owner_t          owner,
  output logic            cpu_busrq_n,
  input  logic            cpu_busack_n,
  output logic            bus_oe,
  output logic            preempt
);

  if (NREQ < 1 || NREQ > 4 || MAX_HOLD < 1 || CPU_SLOT > 255) begin : g_param_check
    $error("z80_bus_arbiter: NREQ must be 1..4, MAX_HOLD >= 1, CPU_SLOT <= 255");
  end

  localparam int unsigned GW = $clog2(GUARD + 2);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, win_onehot;
  owner_t          owner_q, owner_d, last_q, last_d, winner;
  logic            win_valid;
  logic            busrq_n_q, busrq_n_d;
  logic            busack_s_q;
  logic            reclaim_q, reclaim_d;
  logic [GW-1:0]   guard_q, guard_d;
  logic            own_req;

`ifdef Z80_ARB_FAIRNESS_EN
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam int unsigned SW = $clog2(CPU_SLOT + 2);

  logic [HW-1:0] hold_q, hold_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          preempt_q, preempt_d;
  logic          pre_pend_q, pre_pend_d;
  logic          hold_exp;

  // True on the MAX_HOLD-th master-owned cycle since the last IDLE.
  assign hold_exp = (hold_q >= HW'(MAX_HOLD - 1));
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (req),
    .last_owner (last_q),
    .winner     (winner),
    .valid      (win_valid)
  );

  always_comb begin
    win_onehot = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      win_onehot[j] = (owner_t'(j) == winner);
    end
  end

  // gnt_q is one-hot on the owner while granted, so this is req[owner].
  assign own_req = |(req & gnt_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    busrq_n_d = busrq_n_q;
    reclaim_d = reclaim_q;
    guard_d   = guard_q;
`ifdef Z80_ARB_FAIRNESS_EN
    hold_d     = hold_q;
    slot_d     = slot_q;
    preempt_d  = 1'b0;
    pre_pend_d = pre_pend_q;
    if ((state_q == ST_GRANT || state_q == ST_TURN) && hold_q != HW'(MAX_HOLD)) begin
      hold_d = hold_q + HW'(1);
    end
`endif

    case (state_q)
      ST_IDLE: begin
        reclaim_d = 1'b0;
`ifdef Z80_ARB_FAIRNESS_EN
        hold_d = '0;
`endif
        if (|req) begin
          state_d   = ST_ACQ;
          busrq_n_d = 1'b0;
        end
      end

      ST_ACQ: begin
        busrq_n_d = 1'b0;
        if (!busack_s_q) begin
          if (win_valid) begin
            state_d   = ST_GRANT;
            gnt_d     = win_onehot;
            owner_d   = winner;
            last_d    = winner;
            reclaim_d = 1'b0;
          end else begin
            // Every requester withdrew before the CPU acknowledged.
            state_d   = ST_REL;
            busrq_n_d = 1'b1;
          end
        end
      end

      ST_GRANT: begin
        if (!own_req || busack_s_q) begin
          gnt_d     = '0;
          state_d   = ST_TURN;
          guard_d   = GW'(GUARD);
          reclaim_d = busack_s_q;
        end
`ifdef Z80_ARB_FAIRNESS_EN
        else if (hold_exp) begin
          gnt_d      = '0;
          state_d    = ST_TURN;
          guard_d    = GW'(GUARD);
          preempt_d  = 1'b1;
          pre_pend_d = 1'b1;
        end
`endif
      end

      ST_TURN: begin
        if (guard_q != '0) begin
          guard_d = guard_q - GW'(1);
        end else if (reclaim_q) begin
          // CPU took the bus back: re-request it rather than hand off.
          state_d   = win_valid ? ST_ACQ : ST_REL;
          busrq_n_d = !win_valid;
        end
`ifdef Z80_ARB_FAIRNESS_EN
        else if (pre_pend_q) begin
          state_d   = ST_REL;
          busrq_n_d = 1'b1;
        end
`endif
        else if (win_valid) begin
          state_d = ST_GRANT;
          gnt_d   = win_onehot;
          owner_d = winner;
          last_d  = winner;
        end else begin
          state_d   = ST_REL;
          busrq_n_d = 1'b1;
        end
      end

      ST_REL: begin
        busrq_n_d = 1'b1;
        if (busack_s_q) begin
          state_d = ST_IDLE;
`ifdef Z80_ARB_FAIRNESS_EN
          if (pre_pend_q) begin
            state_d = ST_CPU_SLOT;
            slot_d  = SW'(CPU_SLOT);
          end
`endif
        end
      end

`ifdef Z80_ARB_FAIRNESS_EN
      ST_CPU_SLOT: begin
        busrq_n_d = 1'b1;
        if (slot_q > SW'(1)) begin
          slot_d = slot_q - SW'(1);
        end else begin
          state_d    = ST_IDLE;
          pre_pend_d = 1'b0;
        end
      end
`endif

      default: begin
        state_d   = ST_IDLE;
        gnt_d     = '0;
        busrq_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      last_q     <= '0;
      busrq_n_q  <= 1'b1;
      busack_s_q <= 1'b1;
      reclaim_q  <= 1'b0;
      guard_q    <= '0;
    end else if (cen) begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      busrq_n_q  <= busrq_n_d;
      busack_s_q <= cpu_busack_n;
      reclaim_q  <= reclaim_d;
      guard_q    <= guard_d;
    end
  end

`ifdef Z80_ARB_FAIRNESS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      slot_q     <= '0;
      preempt_q  <= 1'b0;
      pre_pend_q <= 1'b0;
    end else if (cen) begin
      hold_q     <= hold_d;
      slot_q     <= slot_d;
      preempt_q  <= preempt_d;
      pre_pend_q <= pre_pend_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  assign gnt         = gnt_q;
  assign owner       = owner_q;
  assign cpu_busrq_n = busrq_n_q;
  assign bus_oe      = |gnt_q;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// tb_z80_bus_arbiter: directed self-checking bench for z80_bus_arbiter
// (NREQ=2, GUARD=1, MAX_HOLD=8, CPU_SLOT=4). The CPU side is modelled by
// driving cpu_busack_n directly. The hold-expiry sequence is exercised when
// Z80_ARB_FAIRNESS_EN is defined; otherwise unbounded ownership is checked.
module tb_z80_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] owner;
  logic       cpu_busrq_n;
  logic       cpu_busack_n;
  logic       bus_oe;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [4:0] exp;  // {gnt, cpu_busrq_n, bus_oe, preempt}
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  z80_bus_arbiter #(
    .NREQ     (2),
    .GUARD    (1),
    .MAX_HOLD (8),
    .CPU_SLOT (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cen          (cen),
    .req          (req),
    .gnt          (gnt),
    .owner        (owner),
    .cpu_busrq_n  (cpu_busrq_n),
    .cpu_busack_n (cpu_busack_n),
    .bus_oe       (bus_oe),
    .preempt      (preempt)
  );

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Push the expected outputs for the coming edge, advance one clock, then
  // pop and compare against what the DUT presents after that edge.
  task automatic step(input string tag, input logic [1:0] g, input logic b,
                      input logic p = 1'b0);
    exp_t e;
    e.tag = tag;
    e.exp = {g, b, |g, p};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e.tag, {gnt, cpu_busrq_n, bus_oe, preempt}, e.exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    cen          = 1'b1;
    req          = 2'b00;
    cpu_busack_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out", {gnt, cpu_busrq_n, bus_oe, preempt}, 5'b00100);
    check("rst_owner", {3'b000, owner}, 5'd0);
    rst_n = 1'b1;

    // Single master, CPU acks a couple of cycles after BUSRQ.
    req = 2'b01;
    step("t1_busrq", 2'b00, 1'b0);
    step("t1_wait", 2'b00, 1'b0);
    cpu_busack_n = 1'b0;
    step("t1_acksync", 2'b00, 1'b0);
    step("t1_grant", 2'b01, 1'b0);
    check("t1_owner", {3'b000, owner}, 5'd0);
    step("t1_hold", 2'b01, 1'b0);
    req = 2'b00;
    step("t1_drop", 2'b00, 1'b0);
    step("t1_guard", 2'b00, 1'b0);
    step("t1_rel", 2'b00, 1'b1);
    cpu_busack_n = 1'b1;
    step("t1_relwait", 2'b00, 1'b1);
    step("t1_idle", 2'b00, 1'b1);

    // Simultaneous requests: master 1 first, gap, then master 0, BUSRQ held.
    req = 2'b11;
    step("t2_busrq", 2'b00, 1'b0);
    cpu_busack_n = 1'b0;
    step("t2_acksync", 2'b00, 1'b0);
    step("t2_grant1", 2'b10, 1'b0);
    check("t2_owner1", {3'b000, owner}, 5'd1);
    req = 2'b01;
    step("t2_drop1", 2'b00, 1'b0);
    step("t2_guard", 2'b00, 1'b0);
    step("t2_grant0", 2'b01, 1'b0);
    check("t2_owner0", {3'b000, owner}, 5'd0);
    req = 2'b00;
    step("t2_drop0", 2'b00, 1'b0);
    step("t2_guard2", 2'b00, 1'b0);
    step("t2_rel", 2'b00, 1'b1);
    cpu_busack_n = 1'b1;
    step("t2_relwait", 2'b00, 1'b1);
    step("t2_idle", 2'b00, 1'b1);

    // Clock-enable freezing in IDLE, GRANT and TURN.
    cen = 1'b0;
    req = 2'b01;
    step("t3_frzidle", 2'b00, 1'b1);
    cen = 1'b1;
    step("t3_busrq", 2'b00, 1'b0);
    cpu_busack_n = 1'b0;
    step("t3_acksync", 2'b00, 1'b0);
    step("t3_grant", 2'b01, 1'b0);
    cen = 1'b0;
    req = 2'b00;
    step("t3_frzgnt1", 2'b01, 1'b0);
    step("t3_frzgnt2", 2'b01, 1'b0);
    cen = 1'b1;
    step("t3_drop", 2'b00, 1'b0);
    cen = 1'b0;
    step("t3_frzturn", 2'b00, 1'b0);
    cen = 1'b1;
    step("t3_guard", 2'b00, 1'b0);
    step("t3_rel", 2'b00, 1'b1);
    cpu_busack_n = 1'b1;
    step("t3_relwait", 2'b00, 1'b1);
    step("t3_idle", 2'b00, 1'b1);

    // Asynchronous reset mid-GRANT, then pointer back at 0.
    req = 2'b10;
    step("t4_busrq", 2'b00, 1'b0);
    cpu_busack_n = 1'b0;
    step("t4_acksync", 2'b00, 1'b0);
    step("t4_grant", 2'b10, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_async", {gnt, cpu_busrq_n, bus_oe, preempt}, 5'b00100);
    check("t4_async_own", {3'b000, owner}, 5'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req = 2'b11;
    step("t4_busrq2", 2'b00, 1'b0);
    step("t4_ptr0", 2'b10, 1'b0);
    check("t4_owner", {3'b000, owner}, 5'd1);
    req = 2'b00;
    step("t4_drop", 2'b00, 1'b0);
    step("t4_guard", 2'b00, 1'b0);
    step("t4_rel", 2'b00, 1'b1);
    cpu_busack_n = 1'b1;
    step("t4_relwait", 2'b00, 1'b1);
    step("t4_idle", 2'b00, 1'b1);

    // CPU reclaims the bus during GRANT.
    req = 2'b01;
    step("t5_busrq", 2'b00, 1'b0);
    cpu_busack_n = 1'b0;
    step("t5_acksync", 2'b00, 1'b0);
    step("t5_grant", 2'b01, 1'b0);
    cpu_busack_n = 1'b1;
    step("t5_ackhi", 2'b01, 1'b0);
    step("t5_reclaim", 2'b00, 1'b0);
    step("t5_guard", 2'b00, 1'b0);
    step("t5_acq", 2'b00, 1'b0);
    step("t5_acqwait", 2'b00, 1'b0);
    cpu_busack_n = 1'b0;
    step("t5_acksync2", 2'b00, 1'b0);
    step("t5_regrant", 2'b01, 1'b0);
    req = 2'b00;
    step("t5_drop", 2'b00, 1'b0);
    step("t5_guard2", 2'b00, 1'b0);
    step("t5_rel", 2'b00, 1'b1);
    cpu_busack_n = 1'b1;
    step("t5_relwait", 2'b00, 1'b1);
    step("t5_idle", 2'b00, 1'b1);

    // Master holding req indefinitely.
    req = 2'b01;
    step("t6_busrq", 2'b00, 1'b0);
    cpu_busack_n = 1'b0;
    step("t6_acksync", 2'b00, 1'b0);
    step("t6_grant", 2'b01, 1'b0);
`ifdef Z80_ARB_FAIRNESS_EN
    for (int i = 0; i < 7; i++) begin
      step("t6_hold", 2'b01, 1'b0);
    end
    step("t6_preempt", 2'b00, 1'b0, 1'b1);
    step("t6_guard", 2'b00, 1'b0);
    step("t6_rel", 2'b00, 1'b1);
    cpu_busack_n = 1'b1;
    step("t6_relwait", 2'b00, 1'b1);
    step("t6_slot_in", 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("t6_slot", 2'b00, 1'b1);
    end
    step("t6_idle", 2'b00, 1'b1);
    step("t6_reacq", 2'b00, 1'b0);
    cpu_busack_n = 1'b0;
    step("t6_acksync2", 2'b00, 1'b0);
    step("t6_regrant", 2'b01, 1'b0);
`else
    for (int i = 0; i < 12; i++) begin
      step("t6_unbounded", 2'b01, 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
